// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path: state encoding and default widths.
// Reused by the IR and the control unit so all agree on sizes and encodings.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

    // Wait counter must be able to hold the value TIMEOUT itself.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: load has priority over increment; increment wraps at 2^ADDR_W.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg_q <= '0;
        end else if (load) begin
            pc_reg_q <= load_addr;
        end else if (inc) begin
            pc_reg_q <= pc_reg_q + ADDR_W'(1);
        end
    end

    assign pc = pc_reg_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: issues one program-memory read per request,
// waits for mem_ready with a timeout, writes the IR and advances the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir_in,
    output logic              ir_w,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    localparam int CNT_W = wait_cnt_width(TIMEOUT);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [CNT_W-1:0]  wait_cnt_next;
    logic [DATA_W-1:0] ir_reg;
    logic              mem_rd_reg;
    logic              ir_w_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              pc_load_en;
    logic              pc_inc;

    assign wait_cnt_next = wait_cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (fetch_req) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // A late ready on the final allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    state_next = ST_LOAD;
                end else if (wait_cnt_next >= CNT_W'(TIMEOUT)) begin
                    state_next = ST_ERR;
                end
            end
            ST_LOAD: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            ir_reg       <= '0;
            mem_rd_reg   <= 1'b0;
            ir_w_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_rd_reg <= (state_next == ST_REQ);
            ir_w_reg   <= (state_next == ST_LOAD);
            busy_reg   <= (state_next != ST_IDLE);
            done_reg   <= (state_next == ST_DONE);
            err_reg    <= (state_next == ST_ERR);

            // Held at zero outside REQ, so every REQ entry starts from a cleared count.
            if (state_reg != ST_REQ) begin
                wait_cnt_reg <= '0;
            end else if (!mem_ready) begin
                wait_cnt_reg <= wait_cnt_next;
            end

            if (state_reg == ST_REQ && mem_ready) begin
                ir_reg <= mem_rdata;
            end
        end
    end

    // Load only in IDLE so a coincident fetch_req reads from the new target.
    assign pc_load_en = (state_reg == ST_IDLE) && pc_load;
    assign pc_inc     = (state_reg == ST_LOAD);

    pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load_en),
        .load_addr (pc_load_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign mem_rd     = mem_rd_reg;
    assign mem_addr   = mem_rd_reg ? pc : '0;
    assign ir_in      = ir_reg;
    assign ir_w       = ir_w_reg;
    assign busy       = busy_reg;
    assign fetch_done = done_reg;
    assign fetch_err  = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the driver pushes expected fetch
// outcomes from a transaction-level model, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_req = 1'b0;
    logic              pc_load = 1'b0;
    logic [ADDR_W-1:0] pc_load_addr = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] ir_in;
    logic              ir_w;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fetch_done;
    logic              fetch_err;

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .ir_in        (ir_in),
        .ir_w         (ir_w),
        .pc           (pc),
        .busy         (busy),
        .fetch_done   (fetch_done),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                ok;
        logic [ADDR_W-1:0] addr;
        int                rd_len;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc_after;
    } exp_t;

    exp_t              exp_q[$];
    int                checks = 0;
    int                failures = 0;
    int                txn_id = 0;
    int                model_pc = 0;
    logic [DATA_W-1:0] model_ir = '0;
    bit                mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h with no pending fetch (t=%0t)", name, act, $time);
    endtask

    // One fetch. d = cycles of REQ before mem_ready; d >= TIMEOUT means never ready.
    task automatic do_fetch(input bit load, input int addr, input int d,
                            input logic [DATA_W-1:0] data, input bit poke, input bit noise);
        exp_t e;
        if (load) model_pc = addr;
        e.addr = ADDR_W'(model_pc);
        if (d < TIMEOUT) begin
            e.ok     = 1'b1;
            e.rd_len = d + 1;
            e.data   = data;
            model_ir = data;
            model_pc = (model_pc + 1) % (1 << ADDR_W);
        end else begin
            e.ok     = 1'b0;
            e.rd_len = TIMEOUT;
            e.data   = model_ir;
        end
        e.pc_after = ADDR_W'(model_pc);
        exp_q.push_back(e);
        $display("txn %0d: load=%0b addr=%03h delay=%0d data=%04h -> %s", txn_id, load,
                 e.addr, d, data, e.ok ? "done" : "timeout");
        txn_id++;

        @(negedge clk);
        fetch_req    = 1'b1;
        pc_load      = load;
        pc_load_addr = ADDR_W'(addr);
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            mem_rdata = DATA_W'($urandom);
            if (noise) begin
                fetch_req    = 1'($urandom_range(0, 1));
                pc_load      = 1'($urandom_range(0, 1));
                pc_load_addr = ADDR_W'($urandom);
            end
            if (i == d) begin
                mem_ready = 1'b1;
                mem_rdata = data;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            if (i == d) break;
        end
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        if (e.ok && poke) begin
            fetch_req    = 1'b1;
            pc_load      = 1'b1;
            pc_load_addr = ADDR_W'($urandom);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        if (e.ok) @(negedge clk);
    endtask

    initial begin : monitor
        int                rd_run;
        bit                in_txn, pend_done, req_pend, prev_rd, done_now;
        logic [ADDR_W-1:0] exp_pc;
        logic [DATA_W-1:0] last_ir;
        exp_t              e;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                rd_run = 0; in_txn = 0; pend_done = 0; req_pend = 0; prev_rd = 0;
                exp_pc = '0; last_ir = '0;
                continue;
            end
            done_now = 1'b0;
            chk("busy", busy, in_txn);
            if (!in_txn) chk("ir_hold", ir_in, last_ir);
            if (req_pend) begin
                chk("rd_latency", mem_rd, 1);
                req_pend = 1'b0;
            end
            if (mem_rd) begin
                if (exp_q.size() == 0) flag("unexpected_mem_rd", mem_addr);
                else chk("mem_addr", mem_addr, exp_q[0].addr);
                rd_run++;
            end else begin
                chk("mem_addr_idle", mem_addr, 0);
            end
            if (pend_done) begin
                chk("fetch_done", fetch_done, 1);
                chk("pc_after_done", pc, exp_pc);
                pend_done = 1'b0;
                done_now  = 1'b1;
            end else if (fetch_done) begin
                flag("unexpected_fetch_done", fetch_done);
            end
            if (ir_w) begin
                if (exp_q.size() == 0) flag("unexpected_ir_w", ir_in);
                else begin
                    e = exp_q.pop_front();
                    chk("ir_w", ir_w, e.ok);
                    chk("rd_cycles", rd_run, e.rd_len);
                    chk("rd_before_ir_w", prev_rd, 1);
                    chk("ir_in", ir_in, e.data);
                    exp_pc    = e.pc_after;
                    last_ir   = ir_in;
                    pend_done = 1'b1;
                end
                rd_run = 0;
            end
            if (fetch_err) begin
                if (exp_q.size() == 0) flag("unexpected_fetch_err", fetch_err);
                else begin
                    e = exp_q.pop_front();
                    chk("fetch_err", fetch_err, !e.ok);
                    chk("err_rd_cycles", rd_run, e.rd_len);
                    chk("err_pc", pc, e.pc_after);
                    chk("err_ir_in", ir_in, e.data);
                end
                rd_run   = 0;
                done_now = 1'b1;
            end
            prev_rd = mem_rd;
            if (done_now) in_txn = 1'b0;
            else if (!in_txn && fetch_req) begin
                in_txn   = 1'b1;
                req_pend = 1'b1;
            end
        end
    end

    initial begin : stimulus
        int r, d;
        #2;
        chk("reset_pc", pc, 0);
        chk("reset_ir_in", ir_in, 0);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {mem_rd, ir_w, fetch_done, fetch_err}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        do_fetch(0, 0, 0, 16'hA5C3, 0, 0);
        do_fetch(0, 0, 4, 16'h3C5A, 0, 0);
        do_fetch(0, 0, TIMEOUT, 16'h0000, 0, 0);
        do_fetch(1, 10'h3FF, 0, 16'h7E81, 0, 0);
        do_fetch(1, 5, 2, 16'h0F0F, 1, 0);
        do_fetch(0, 0, TIMEOUT - 1, 16'hBEEF, 0, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r            = int'($urandom_range(0, (1 << ADDR_W) - 1));
                pc_load      = 1'b1;
                pc_load_addr = ADDR_W'(r);
                model_pc     = r;
                @(negedge clk);
                pc_load = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = int'($urandom_range(0, 9));
            if (r < 6) d = r;
            else if (r == 6) d = TIMEOUT - 1;
            else if (r == 7) d = TIMEOUT;
            else d = int'($urandom_range(0, 3));
            r = ($urandom_range(0, 3) == 0) ? 10'h3FF : int'($urandom_range(0, (1 << ADDR_W) - 1));
            do_fetch(1'($urandom_range(0, 2) == 0), r, d, DATA_W'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Known nonzero IR before the mid-REQ reset.
        do_fetch(0, 0, 1, 16'h1234, 0, 0);
        mon_en = 1'b0;
        @(negedge clk);
        fetch_req    = 1'b1;
        pc_load      = 1'b1;
        pc_load_addr = 10'd5;
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        chk("pre_reset_pc", pc, 5);
        chk("pre_reset_mem_rd", mem_rd, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_pc", pc, 0);
        chk("async_reset_ir_in", ir_in, 0);
        chk("async_reset_strobes", {mem_rd, ir_w, fetch_done, fetch_err}, 0);
        chk("async_reset_mem_addr", mem_addr, 0);
        exp_q.delete();
        model_pc = 0;
        model_ir = '0;
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        do_fetch(0, 0, 1, 16'hC0DE, 0, 0);
        do_fetch(0, 0, 0, 16'h4321, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
